// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single data-memory port between the core (PS/DAG/BC)
// and a host/debug requester. The core has priority. A starvation counter forces
// a host slot after STARVE_LIM denied host cycles. Synchronous-RAM read data is
// steered back to whichever requester issued the read.
// Optional feature: define DM_ARB_RR_EN for fair round-robin arbitration.
// That mode replaces the starvation counter, and STARVE_LIM is then ignored.
module dm_arbiter #(
    parameter int unsigned DMA_SIZE   = 16,
    parameter int unsigned DMD_SIZE   = 16,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    // core side
    input  logic                ps_arb_req,
    input  logic                ps_arb_wrb,
    input  logic [DMA_SIZE-1:0] dg_arb_add,
    input  logic [DMD_SIZE-1:0] bc_arb_dt,
    output logic                arb_ps_gnt,
    output logic                arb_ps_stall,
    output logic [DMD_SIZE-1:0] arb_bc_dt,
    output logic                arb_bc_vld,
    // host side
    input  logic                hst_arb_req,
    input  logic                hst_arb_wrb,
    input  logic [DMA_SIZE-1:0] hst_arb_add,
    input  logic [DMD_SIZE-1:0] hst_arb_dt,
    output logic                arb_hst_gnt,
    output logic [DMD_SIZE-1:0] arb_hst_dt,
    output logic                arb_hst_vld,
    // memory side
    output logic                arb_dm_cslt,
    output logic                arb_dm_wrb,
    output logic [DMA_SIZE-1:0] arb_dm_add,
    output logic [DMD_SIZE-1:0] arb_dm_dt,
    input  logic [DMD_SIZE-1:0] dm_arb_dt
);

    // Outstanding read: set for one cycle after a granted read.
    logic rd_pend;
    // Owner of the outstanding read: 1 = host, 0 = core.
    logic rd_host;

`ifdef DM_ARB_RR_EN

    // Winner of the most recent grant: 1 = host, 0 = core.
    // It resets to host, so the core wins the first conflict after reset.
    logic last_win;

    // Round-robin grant: on a conflict, the requester that did not win last gets the port.
    always_comb begin
        arb_ps_gnt  = ps_arb_req;
        arb_hst_gnt = hst_arb_req;
        if (ps_arb_req && hst_arb_req) begin
            arb_ps_gnt  = last_win;
            arb_hst_gnt = ~last_win;
        end
    end

    // Track the last winner. An uncontested grant also counts as a win.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_win <= 1'b1;
        end else if (arb_ps_gnt) begin
            last_win <= 1'b0;
        end else if (arb_hst_gnt) begin
            last_win <= 1'b1;
        end
    end

`else

    typedef enum logic {
        PRI_CORE = 1'b0,
        PRI_HOST = 1'b1
    } pri_t;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    pri_t             state;
    pri_t             state_nxt;
    logic [CNT_W-1:0] hst_wait;
    logic [CNT_W-1:0] hst_wait_nxt;

    // Priority grant. The host wins in PRI_HOST, or when the core is idle.
    always_comb begin
        arb_hst_gnt = hst_arb_req & ((state == PRI_HOST) | ~ps_arb_req);
        arb_ps_gnt  = ps_arb_req & ~arb_hst_gnt;
    end

    // Next host wait count and next priority state.
    always_comb begin
        hst_wait_nxt = hst_wait;
        if (arb_hst_gnt) begin
            hst_wait_nxt = '0;
        end else if (hst_arb_req) begin
            if (hst_wait != '1) begin
                hst_wait_nxt = hst_wait + 1'b1;
            end
        end else if (state == PRI_HOST) begin
            hst_wait_nxt = '0;
        end

        state_nxt = state;
        if (state == PRI_HOST) begin
            if (arb_hst_gnt || !hst_arb_req) begin
                state_nxt = PRI_CORE;
            end
        end else if ((LIM != '0) && (hst_wait_nxt >= LIM)) begin
            state_nxt = PRI_HOST;
        end
    end

    // Priority FSM and starvation counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PRI_CORE;
            hst_wait <= '0;
        end else begin
            state    <= state_nxt;
            hst_wait <= hst_wait_nxt;
        end
    end

`endif

    // Mux the winner's access onto the memory port; the port is driven to zero when idle.
    always_comb begin
        arb_dm_cslt = arb_ps_gnt | arb_hst_gnt;
        arb_dm_wrb  = 1'b0;
        arb_dm_add  = '0;
        arb_dm_dt   = '0;
        if (arb_ps_gnt) begin
            arb_dm_wrb = ps_arb_wrb;
            arb_dm_add = dg_arb_add;
            arb_dm_dt  = bc_arb_dt;
        end else if (arb_hst_gnt) begin
            arb_dm_wrb = hst_arb_wrb;
            arb_dm_add = hst_arb_add;
            arb_dm_dt  = hst_arb_dt;
        end
        arb_ps_stall = ps_arb_req & ~arb_ps_gnt;
    end

    // Remember who issued a read, so the returning data can be routed back next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_host <= 1'b0;
        end else begin
            rd_pend <= arb_dm_cslt & ~arb_dm_wrb;
            rd_host <= arb_hst_gnt;
        end
    end

    // Route the RAM read data to the owner.
    // Gating with reset drops a return that is still in flight when reset arrives.
    always_comb begin
        arb_bc_vld  = rd_pend & ~rd_host & ~reset;
        arb_hst_vld = rd_pend & rd_host & ~reset;
        arb_bc_dt   = arb_bc_vld  ? dm_arb_dt : '0;
        arb_hst_dt  = arb_hst_vld ? dm_arb_dt : '0;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter (default build,
// core priority with STARVE_LIM = 4) against a behavioural model in the bench.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps_arb_req, ps_arb_wrb;
    logic [15:0] dg_arb_add, bc_arb_dt;
    logic        arb_ps_gnt, arb_ps_stall, arb_bc_vld;
    logic [15:0] arb_bc_dt;
    logic        hst_arb_req, hst_arb_wrb;
    logic [15:0] hst_arb_add, hst_arb_dt;
    logic        arb_hst_gnt, arb_hst_vld;
    logic [15:0] arb_hst_dt;
    logic        arb_dm_cslt, arb_dm_wrb;
    logic [15:0] arb_dm_add, arb_dm_dt, dm_arb_dt;

    always #5 clk = ~clk;

    dm_arbiter #(.DMA_SIZE(16), .DMD_SIZE(16), .STARVE_LIM(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .ps_arb_req(ps_arb_req), .ps_arb_wrb(ps_arb_wrb), .dg_arb_add(dg_arb_add),
        .bc_arb_dt(bc_arb_dt), .arb_ps_gnt(arb_ps_gnt), .arb_ps_stall(arb_ps_stall),
        .arb_bc_dt(arb_bc_dt), .arb_bc_vld(arb_bc_vld),
        .hst_arb_req(hst_arb_req), .hst_arb_wrb(hst_arb_wrb), .hst_arb_add(hst_arb_add),
        .hst_arb_dt(hst_arb_dt), .arb_hst_gnt(arb_hst_gnt), .arb_hst_dt(arb_hst_dt),
        .arb_hst_vld(arb_hst_vld),
        .arb_dm_cslt(arb_dm_cslt), .arb_dm_wrb(arb_dm_wrb), .arb_dm_add(arb_dm_add),
        .arb_dm_dt(arb_dm_dt), .dm_arb_dt(dm_arb_dt)
    );

    // Synchronous RAM environment (256 words, indexed by the low address byte).
    logic [15:0] ram [256];
    logic [15:0] rd_q = 16'h0;
    assign dm_arb_dt = rd_q;
    always @(posedge clk) begin
        if (arb_dm_cslt) begin
            if (arb_dm_wrb) ram[arb_dm_add[7:0]] <= arb_dm_dt;
            else            rd_q <= ram[arb_dm_add[7:0]];
        end
    end

    // Reference model state
    logic [15:0] mmem [256];
    bit          m_hpri;     // host has forced priority
    int          m_wait;     // host denied-cycle count
    bit          m_pend;     // read return due this cycle
    bit          m_phost;    // that read belongs to the host
    logic [15:0] m_data;     // data that read must return

    // Observed outputs of the last cycle
    logic        o_pg, o_hg, o_stall, o_bv, o_hv;
    logic [15:0] o_bdt, o_hdt;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model.
    task automatic cycle(input logic rst, input logic pr, input logic pw,
                         input logic [15:0] pa, input logic [15:0] pd,
                         input logic hr, input logic hw,
                         input logic [15:0] ha, input logic [15:0] hd);
        bit e_pg, e_hg, e_bv, e_hv, win_w;
        logic [15:0] win_a, win_d, e_bdt, e_hdt;
        reset = rst;
        ps_arb_req = pr; ps_arb_wrb = pw; dg_arb_add = pa; bc_arb_dt = pd;
        hst_arb_req = hr; hst_arb_wrb = hw; hst_arb_add = ha; hst_arb_dt = hd;

        // Core wins unless the host holds forced priority or the core is idle.
        e_hg  = hr && (m_hpri || !pr);
        e_pg  = pr && !e_hg;
        win_w = e_pg ? pw : (e_hg ? hw : 1'b0);
        win_a = e_pg ? pa : (e_hg ? ha : 16'h0);
        win_d = e_pg ? pd : (e_hg ? hd : 16'h0);
        e_bv  = m_pend && !m_phost && !rst;
        e_hv  = m_pend && m_phost && !rst;
        e_bdt = e_bv ? m_data : 16'h0;
        e_hdt = e_hv ? m_data : 16'h0;

        @(negedge clk);
        o_pg = arb_ps_gnt; o_hg = arb_hst_gnt; o_stall = arb_ps_stall;
        o_bv = arb_bc_vld; o_hv = arb_hst_vld; o_bdt = arb_bc_dt; o_hdt = arb_hst_dt;
        check("ps_gnt",   arb_ps_gnt,   e_pg);
        check("hst_gnt",  arb_hst_gnt,  e_hg);
        check("ps_stall", arb_ps_stall, pr && !e_pg);
        check("dm_cslt",  arb_dm_cslt,  e_pg || e_hg);
        check("dm_wrb",   arb_dm_wrb,   win_w);
        check("dm_add",   arb_dm_add,   win_a);
        check("dm_dt",    arb_dm_dt,    win_d);
        check("bc_vld",   arb_bc_vld,   e_bv);
        check("bc_dt",    arb_bc_dt,    e_bdt);
        check("hst_vld",  arb_hst_vld,  e_hv);
        check("hst_dt",   arb_hst_dt,   e_hdt);

        // Advance the model to the next cycle.
        m_pend = 1'b0;
        if (e_pg || e_hg) begin
            if (win_w) mmem[win_a[7:0]] = win_d;
            else begin
                m_pend  = 1'b1;
                m_phost = e_hg;
                m_data  = mmem[win_a[7:0]];
            end
        end
        if (e_hg)        m_wait = 0;
        else if (hr)     m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        else if (m_hpri) m_wait = 0;
        if (m_hpri)           m_hpri = 1'b0;
        else if (m_wait >= 4) m_hpri = 1'b1;
        if (rst) begin
            m_hpri = 1'b0; m_wait = 0; m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] v;
        reset = 1'b1;
        ps_arb_req = 0; ps_arb_wrb = 0; dg_arb_add = 0; bc_arb_dt = 0;
        hst_arb_req = 0; hst_arb_wrb = 0; hst_arb_add = 0; hst_arb_dt = 0;
        m_hpri = 0; m_wait = 0; m_pend = 0; m_phost = 0; m_data = 0;
        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            ram[i] = v;
            mmem[i] = v;
        end
        ram[8'h10]  = 16'hBEEF;
        mmem[8'h10] = 16'hBEEF;
        @(posedge clk);
        #1;
        idle(1'b1);
        idle(1'b1);
        check("rst_bvld", o_bv, 1'b0);
        check("rst_hvld", o_hv, 1'b0);

        // Core read, host idle: returns one cycle later to the core.
        cycle(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
        check("t1_pgnt", o_pg, 1'b1);
        idle(1'b0);
        check("t1_bvld", o_bv, 1'b1);
        check("t1_bdt",  o_bdt, 16'hBEEF);
        check("t1_hvld", o_hv, 1'b0);

        // Continuous contention: the host gets every fifth slot.
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 16'($urandom), 16'($urandom), 1, 0, 16'($urandom), 16'($urandom));
            check("t2_hgnt",  o_hg,    (i % 5) == 4);
            check("t2_stall", o_stall, (i % 5) == 4);
        end

        // Core write followed by a host read of the same address.
        cycle(0, 1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
        check("t3_hgnt", o_hg, 1'b1);
        idle(1'b0);
        check("t3_hvld", o_hv, 1'b1);
        check("t3_hdt",  o_hdt, 16'h1234);

        // Alternating core and host reads: back-to-back returns to the right owner.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle(0, 1, 0, 16'($urandom), 16'h0, 0, 0, 16'h0, 16'h0);
            else            cycle(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'($urandom), 16'h0);
            if (i > 0) check("t4_vld", (i % 2 == 1) ? o_bv : o_hv, 1'b1);
        end
        idle(1'b0);

        // Reset right after a core read grant drops the return and clears the starvation count.
        cycle(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h0, 16'h0);
        cycle(0, 1, 0, 16'h0011, 16'h0, 1, 0, 16'h0, 16'h0);
        idle(1'b1);
        check("t5_bvld", o_bv, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 16'($urandom), 16'h0, 1, 0, 16'($urandom), 16'h0);
            check("t5_hgnt", o_hg, i == 4);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                  16'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
